// File: rtl/adc_mod_multi_pkg.sv
`default_nettype none
// ============================================================================
// Package : adc_mod_pkg
// Brief   : Field offsets, lane modes and saturation helper for adc_mod_multi.
// Revision: 1.0 - initial release
// ============================================================================
package adc_mod_pkg;

    localparam logic [1:0] FLD_CENTER = 2'd0;
    localparam logic [1:0] FLD_KF     = 2'd1;
    localparam logic [1:0] FLD_CHSEL  = 2'd2;
    localparam logic [1:0] FLD_MODE   = 2'd3;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Clamp a signed sum into the unsigned 32-bit range.
    function automatic logic [31:0] sat_u32(input logic signed [63:0] x);
        logic [31:0] r;
        if (x < 64'sd0)
            r = 32'h0000_0000;
        else if (x > 64'sh0000_0000_FFFF_FFFF)
            r = 32'hFFFF_FFFF;
        else
            r = x[31:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_mod_multi_if.sv
`default_nettype none
// ============================================================================
// Interface: adc_mod_multi_if
// Brief    : Parameter-write, ADC sample and modulation-output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_mod_multi_if #(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH    = 2,
    parameter int NUM_OUT   = 2
);
    localparam int c_AW = $clog2(NUM_OUT) + 2;

    logic                          param_wen;
    logic [c_AW-1:0]               param_addr;
    logic [31:0]                   param_wdata;
    logic                          param_commit;
    logic                          en;
    logic                          adc_valid;
    logic [NUM_CH*ADC_WIDTH-1:0]   adc_data;
    logic                          mod_valid;
    logic [NUM_OUT*32-1:0]         mod_out;

    modport master (
        output param_wen, param_addr, param_wdata, param_commit,
        output en, adc_valid, adc_data,
        input  mod_valid, mod_out
    );

    modport slave (
        input  param_wen, param_addr, param_wdata, param_commit,
        input  en, adc_valid, adc_data,
        output mod_valid, mod_out
    );
endinterface
`default_nettype wire

// File: rtl/adc_mod_multi_lane.sv
`default_nettype none
// ============================================================================
// Module  : adc_mod_lane
// Brief   : One modulation lane: active parameters plus the S1..S3 pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module adc_mod_lane
    import adc_mod_pkg::*;
#(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH    = 2,
    parameter int KF_SHIFT  = 11,
    parameter int CH_W      = 1
) (
    input  wire logic                        clk,
    input  wire logic                        rstn,
    input  wire logic                        i_en,
    input  wire logic                        i_commit,
    input  wire logic [31:0]                 i_sh_center,
    input  wire logic [31:0]                 i_sh_kf,
    input  wire logic [CH_W-1:0]             i_sh_ch,
    input  wire logic                        i_sh_ch_inv,
    input  wire logic                        i_sh_mode,
    input  wire logic                        i_acc,
    input  wire logic                        i_v1,
    input  wire logic                        i_v2,
    input  wire logic                        i_v3,
    input  wire logic [NUM_CH*ADC_WIDTH-1:0] i_adc_data,
    output logic      [31:0]                 o_mod
);
    localparam int c_PW   = ADC_WIDTH + 33;
    localparam int c_SUMW = c_PW + 1;

    logic [31:0]            r_center, r_kf;
    logic [CH_W-1:0]        r_ch;
    logic                   r_ch_inv, r_mode;

    logic signed [ADC_WIDTH-1:0] r_s1;
    logic [31:0]            r_s1_kf, r_s1_center, r_s2_center;
    logic                   r_s1_mode, r_s2_mode, r_s3_mode;
    logic signed [c_PW-1:0] r_p;
    logic signed [c_SUMW-1:0] r_sum;
    logic [31:0]            r_mod;

    logic [ADC_WIDTH-1:0]        w_raw;
    logic signed [ADC_WIDTH-1:0] w_s;
    logic signed [c_PW-1:0]      w_a, w_b, w_d;
    logic signed [c_SUMW-1:0]    w_sum;
    logic [31:0]                 w_word;

    always_comb begin
        w_raw = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c))
                w_raw = i_adc_data[c*ADC_WIDTH +: ADC_WIDTH];
        end
    end

    // Offset-binary to two's complement is an MSB flip.
    assign w_s    = r_ch_inv ? '0 : $signed({~w_raw[ADC_WIDTH-1], w_raw[ADC_WIDTH-2:0]});
    assign w_a    = c_PW'(r_s1);
    assign w_b    = c_PW'($signed({1'b0, r_s1_kf}));
    assign w_d    = r_p >>> KF_SHIFT;
    assign w_sum  = c_SUMW'(w_d) + $signed({{(c_SUMW-32){1'b0}}, r_s2_center});
    assign w_word = (r_s3_mode == MODE_SAT) ? sat_u32(64'(r_sum)) : r_sum[31:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_center    <= '0;
            r_kf        <= '0;
            r_ch        <= '0;
            r_ch_inv    <= 1'b0;
            r_mode      <= MODE_WRAP;
            r_s1        <= '0;
            r_s1_kf     <= '0;
            r_s1_center <= '0;
            r_s1_mode   <= 1'b0;
            r_p         <= '0;
            r_s2_center <= '0;
            r_s2_mode   <= 1'b0;
            r_sum       <= '0;
            r_s3_mode   <= 1'b0;
            r_mod       <= '0;
        end else begin
            if (i_commit) begin
                r_center <= i_sh_center;
                r_kf     <= i_sh_kf;
                r_ch     <= i_sh_ch;
                r_ch_inv <= i_sh_ch_inv;
                r_mode   <= i_sh_mode;
            end
            // Parameters ride with the sample so a later commit cannot disturb it.
            if (i_acc) begin
                r_s1        <= w_s;
                r_s1_kf     <= r_kf;
                r_s1_center <= r_center;
                r_s1_mode   <= r_mode;
            end
            if (i_v1) begin
                r_p         <= w_a * w_b;
                r_s2_center <= r_s1_center;
                r_s2_mode   <= r_s1_mode;
            end
            if (i_v2) begin
                r_sum     <= w_sum;
                r_s3_mode <= r_s2_mode;
            end
            if (!i_en)
                r_mod <= '0;
            else if (i_v3)
                r_mod <= w_word;
        end
    end

    assign o_mod = r_mod;

endmodule
`default_nettype wire

// File: rtl/adc_mod_multi.sv
`default_nettype none
// ============================================================================
// Module  : adc_mod_multi
// Brief   : Multi-channel ADC to multi-lane DDS modulation words, double-buffered.
// Revision: 1.0 - initial release
// ============================================================================
module adc_mod_multi
    import adc_mod_pkg::*;
#(
    parameter int ADC_WIDTH = 12,
    parameter int NUM_CH    = 2,
    parameter int NUM_OUT   = 2,
    parameter int KF_SHIFT  = 11
) (
    input  wire logic      clk,
    input  wire logic      rstn,
    adc_mod_multi_if.slave bus
);
    localparam int c_AW  = $clog2(NUM_OUT) + 2;
    localparam int c_CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic r_v1, r_v2, r_v3, r_mod_valid;
    logic w_acc;

    assign w_acc = bus.adc_valid & bus.en;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_mod_valid <= 1'b0;
        end else begin
            r_v1        <= w_acc;
            r_v2        <= r_v1 & bus.en;
            r_v3        <= r_v2 & bus.en;
            r_mod_valid <= r_v3 & bus.en;
        end
    end

    assign bus.mod_valid = r_mod_valid;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        logic [31:0]      r_sh_center, r_sh_kf;
        logic [c_CHW-1:0] r_sh_ch;
        logic             r_sh_inv, r_sh_mode;
        logic             w_hit;
        logic [31:0]      w_mod;

        assign w_hit = bus.param_wen && ((bus.param_addr >> 2) == c_AW'(k));

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_sh_center <= '0;
                r_sh_kf     <= '0;
                r_sh_ch     <= '0;
                r_sh_inv    <= 1'b0;
                r_sh_mode   <= MODE_WRAP;
            end else if (w_hit) begin
                case (bus.param_addr[1:0])
                    FLD_CENTER: r_sh_center <= bus.param_wdata;
                    FLD_KF:     r_sh_kf     <= bus.param_wdata;
                    FLD_CHSEL: begin
                        r_sh_ch  <= bus.param_wdata[c_CHW-1:0];
                        r_sh_inv <= (bus.param_wdata >= 32'(NUM_CH));
                    end
                    FLD_MODE:   r_sh_mode   <= bus.param_wdata[0];
                    default: ;
                endcase
            end
        end

        adc_mod_lane #(
            .ADC_WIDTH (ADC_WIDTH),
            .NUM_CH    (NUM_CH),
            .KF_SHIFT  (KF_SHIFT),
            .CH_W      (c_CHW)
        ) u_lane (
            .clk         (clk),
            .rstn        (rstn),
            .i_en        (bus.en),
            .i_commit    (bus.param_commit),
            .i_sh_center (r_sh_center),
            .i_sh_kf     (r_sh_kf),
            .i_sh_ch     (r_sh_ch),
            .i_sh_ch_inv (r_sh_inv),
            .i_sh_mode   (r_sh_mode),
            .i_acc       (w_acc),
            .i_v1        (r_v1),
            .i_v2        (r_v2),
            .i_v3        (r_v3),
            .i_adc_data  (bus.adc_data),
            .o_mod       (w_mod)
        );

        assign bus.mod_out[k*32 +: 32] = w_mod;
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_mod_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_mod_multi
// Brief   : Self-checking bench: directed table, corner sequences, random model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adc_mod_multi;
    import adc_mod_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    adc_mod_multi_if #(.ADC_WIDTH(12), .NUM_CH(2), .NUM_OUT(2)) bus ();

    adc_mod_multi #(
        .ADC_WIDTH (12),
        .NUM_CH    (2),
        .NUM_OUT   (2),
        .KF_SHIFT  (11)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    string tag      = "init";

    // Reference model: parameter sets and a queue of words due at given edges.
    logic [31:0] sh_center[2], sh_kf[2], sh_ch[2];
    logic        sh_mode[2];
    logic [31:0] act_center[2], act_kf[2], act_ch[2];
    logic        act_mode[2];

    typedef struct { int due; logic [63:0] w; } exp_t;
    exp_t        q[$];
    logic [63:0] last_out = '0;
    logic        exp_valid = 1'b0;

    function automatic logic [31:0] ref_word(input int k, input logic [23:0] data);
        logic [23:0] sh;
        longint s, p, sum;
        if (act_ch[k] >= 32'd2) begin
            s = 0;
        end else begin
            sh = data >> (12 * act_ch[k]);
            s  = longint'({52'h0, sh[11:0]}) - 2048;
        end
        p   = s * longint'({32'h0, act_kf[k]});
        sum = longint'({32'h0, act_center[k]}) + (p >>> 11);
        if (act_mode[k]) begin
            if (sum < 0) return 32'h0;
            if (sum > 64'sh0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        end
        return sum[31:0];
    endfunction

    task automatic model_edge();
        logic [2:0] a;
        int ln;
        cyc++;
        exp_valid = 1'b0;
        if (!rstn) begin
            q.delete();
            last_out = '0;
            for (int k = 0; k < 2; k++) begin
                sh_center[k] = 0; sh_kf[k] = 0; sh_ch[k] = 0; sh_mode[k] = 0;
                act_center[k] = 0; act_kf[k] = 0; act_ch[k] = 0; act_mode[k] = 0;
            end
            return;
        end
        if (!bus.en) begin
            q.delete();
            last_out = '0;
        end else begin
            if (bus.adc_valid)
                q.push_back('{cyc + 3, {ref_word(1, bus.adc_data), ref_word(0, bus.adc_data)}});
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_valid = 1'b1;
                last_out  = q[0].w;
                void'(q.pop_front());
            end
        end
        if (bus.param_commit) begin
            for (int k = 0; k < 2; k++) begin
                act_center[k] = sh_center[k]; act_kf[k] = sh_kf[k];
                act_ch[k] = sh_ch[k]; act_mode[k] = sh_mode[k];
            end
        end
        if (bus.param_wen) begin
            a  = bus.param_addr;
            ln = int'(a[2]);
            case (a[1:0])
                2'd0: sh_center[ln] = bus.param_wdata;
                2'd1: sh_kf[ln]     = bus.param_wdata;
                2'd2: sh_ch[ln]     = bus.param_wdata;
                default: sh_mode[ln] = bus.param_wdata[0];
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        vectors++;
        if (bus.mod_valid !== exp_valid || bus.mod_out !== last_out) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got valid=%0b out=%h, want valid=%0b out=%h",
                     tag, cyc, bus.mod_valid, bus.mod_out, exp_valid, last_out);
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic wr(input int lane, input logic [1:0] fld, input logic [31:0] d);
        bus.param_wen   = 1'b1;
        bus.param_addr  = {lane[0], fld};
        bus.param_wdata = d;
        step();
        bus.param_wen   = 1'b0;
    endtask

    task automatic commit();
        bus.param_commit = 1'b1;
        step();
        bus.param_commit = 1'b0;
    endtask

    task automatic sample(input logic [23:0] d);
        bus.adc_valid = 1'b1;
        bus.adc_data  = d;
        step();
        bus.adc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic setup0(input logic [31:0] c, input logic [31:0] kf,
                          input logic [31:0] ch, input logic m);
        wr(0, FLD_CENTER, c);
        wr(0, FLD_KF, kf);
        wr(0, FLD_CHSEL, ch);
        wr(0, FLD_MODE, {31'h0, m});
        commit();
    endtask

    typedef struct {
        string       name;
        logic [31:0] center;
        logic [31:0] kf;
        logic [31:0] ch;
        logic        mode;
        logic [23:0] data;
        logic [31:0] want;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{"fm_basic",   32'h1000_0000, 32'h1000, 32'd0, MODE_WRAP, 24'h000C00, 32'h1000_0800};
        tbl[1] = '{"fm_neg",     32'h1000_0000, 32'h1000, 32'd0, MODE_WRAP, 24'h000000, 32'h0FFF_F000};
        tbl[2] = '{"fm_mid",     32'h1000_0000, 32'h1000, 32'd0, MODE_WRAP, 24'h000800, 32'h1000_0000};
        tbl[3] = '{"wrap_under", 32'd100,       32'h1000, 32'd0, MODE_WRAP, 24'h000000, 32'hFFFF_F064};
        tbl[4] = '{"sat_under",  32'd100,       32'h1000, 32'd0, MODE_SAT,  24'h000000, 32'h0000_0000};
        tbl[5] = '{"sat_over",   32'hFFFF_FF00, 32'h1000, 32'd0, MODE_SAT,  24'h000FFF, 32'hFFFF_FFFF};
        tbl[6] = '{"ch_invalid", 32'h0000_1234, 32'h1000, 32'd5, MODE_WRAP, 24'h000ABC, 32'h0000_1234};
        tbl[7] = '{"ch1_lane0",  32'h0,         32'h0800, 32'd1, MODE_WRAP, 24'h900123, 32'h0000_0100};

        bus.param_wen = 0; bus.param_addr = 0; bus.param_wdata = 0; bus.param_commit = 0;
        bus.en = 1; bus.adc_valid = 0; bus.adc_data = 0;

        tag = "reset";
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        check("reset_out", bus.mod_out, 64'h0);
        check("reset_valid", {63'h0, bus.mod_valid}, 64'h0);

        tag = "table";
        foreach (tbl[i]) begin
            setup0(tbl[i].center, tbl[i].kf, tbl[i].ch, tbl[i].mode);
            sample(tbl[i].data);
            idle(3);
            check(tbl[i].name, {32'h0, bus.mod_out[31:0]}, {32'h0, tbl[i].want});
            check({tbl[i].name, "_valid"}, {63'h0, bus.mod_valid}, 64'h1);
        end

        tag = "shadow";
        setup0(32'h1000_0000, 32'h1000, 32'd0, MODE_WRAP);
        wr(0, FLD_KF, 32'h2000);
        sample(24'h000C00); idle(3);
        check("shadow_nocommit", {32'h0, bus.mod_out[31:0]}, 64'h1000_0800);
        bus.param_commit = 1'b1;
        wr(0, FLD_KF, 32'h3000);
        bus.param_commit = 1'b0;
        sample(24'h000C00); idle(3);
        check("shadow_same_cycle", {32'h0, bus.mod_out[31:0]}, 64'h1000_1000);
        commit();
        sample(24'h000C00); idle(3);
        check("shadow_later_commit", {32'h0, bus.mod_out[31:0]}, 64'h1000_1800);

        tag = "chsel";
        setup0(32'h0, 32'h0800, 32'd0, MODE_WRAP);
        wr(1, FLD_CENTER, 32'h0);
        wr(1, FLD_KF, 32'h0800);
        wr(1, FLD_CHSEL, 32'd1);
        commit();
        sample(24'h700900); idle(3);
        check("chsel_two_lanes", bus.mod_out, 64'hFFFF_FF00_0000_0100);
        wr(1, FLD_CENTER, 32'h0000_5678);
        wr(1, FLD_CHSEL, 32'd5);
        commit();
        sample(24'hFFF000); idle(3);
        check("chsel_invalid_lane1", {32'h0, bus.mod_out[63:32]}, 64'h5678);

        tag = "enable";
        setup0(32'h1000_0000, 32'h1000, 32'd0, MODE_WRAP);
        bus.adc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.adc_data = 24'($urandom);
            step();
        end
        bus.en = 1'b0;
        step();
        check("en_drop_out", bus.mod_out, 64'h0);
        check("en_drop_valid", {63'h0, bus.mod_valid}, 64'h0);
        bus.adc_valid = 1'b0;
        idle(3);
        bus.en = 1'b1;
        sample(24'h000C00); idle(2);
        check("en_restart_early", {63'h0, bus.mod_valid}, 64'h0);
        idle(1);
        check("en_restart", {32'h0, bus.mod_out[31:0]}, 64'h1000_0800);

        tag = "rst_mid";
        bus.adc_valid = 1'b1;
        bus.adc_data  = 24'h000C00;
        idle(2);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        bus.adc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_stale", {63'h0, bus.mod_valid}, 64'h0);
        end
        sample(24'h000FFF); idle(3);
        check("rst_params_zero", bus.mod_out, 64'h0);
        commit();
        sample(24'h000123); idle(3);
        check("rst_shadow_zero", bus.mod_out, 64'h0);

        tag = "random";
        for (int i = 0; i < 2000; i++) begin
            rstn             = ($urandom_range(0, 299) != 0);
            bus.en           = ($urandom_range(0, 15) != 0);
            bus.adc_valid    = 1'($urandom_range(0, 1));
            bus.adc_data     = 24'($urandom);
            bus.param_wen    = ($urandom_range(0, 3) == 0);
            bus.param_addr   = 3'($urandom_range(0, 7));
            bus.param_commit = ($urandom_range(0, 7) == 0);
            case (bus.param_addr[1:0])
                2'd1:    bus.param_wdata = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 16'hFFFF)) : $urandom;
                2'd2:    bus.param_wdata = ($urandom_range(0, 4) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
                default: bus.param_wdata = $urandom;
            endcase
            step();
        end
        rstn = 1'b1; bus.en = 1'b1; bus.adc_valid = 1'b0;
        bus.param_wen = 1'b0; bus.param_commit = 1'b0;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
